// File: rtl/dff_stream_deser.sv
// dff_stream_deser: start/stop framed serial receiver (LSB first) feeding a
// one-word valid/ready output register, with framing-error pulse and sticky overrun.
module dff_stream_deser #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              bit_vld,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    input  logic              data_rdy,
    output logic              frm_err,
    output logic              ovr_err,
    input  logic              clr_err
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_RESYNC} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift, r_data;
    logic              r_vld, r_frm, r_ovr;
    logic              w_done, w_bad, w_load, w_ovr;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_bad  = 1'b0;
        if (bit_vld) begin
            case (r_state)
                S_IDLE:  w_next = ser_in ? S_IDLE : S_DATA;
                S_DATA:  w_next = (r_cnt == LAST) ? S_STOP : S_DATA;
                S_STOP: begin
                    w_next = ser_in ? S_IDLE : S_RESYNC;
                    w_done = ser_in;
                    w_bad  = ~ser_in;
                end
                default: w_next = ser_in ? S_IDLE : S_RESYNC;
            endcase
        end
    end

    // A finished word loads if the output slot is empty or drains on this same edge.
    assign w_load = w_done & (~r_vld | data_rdy);
    assign w_ovr  = w_done & r_vld & ~data_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_frm   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (bit_vld && r_state == S_IDLE && !ser_in) begin
                r_cnt <= '0;
            end else if (bit_vld && r_state == S_DATA) begin
                r_shift[r_cnt] <= ser_in;
                if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
            end
            if (w_load) r_data <= r_shift;
            r_vld <= w_load | (r_vld & ~data_rdy);
            r_frm <= w_bad;
            r_ovr <= w_ovr | (r_ovr & ~clr_err);
        end
    end

    assign data_out = r_data;
    assign data_vld = r_vld;
    assign frm_err  = r_frm;
    assign ovr_err  = r_ovr;
endmodule

// File: tb/tb_dff_stream_deser.sv
// tb_dff_stream_deser: directed and random frames checked against a bit-stream
// parsing model of the framing rules.
module tb_dff_stream_deser;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, ser_in, bit_vld, data_rdy, clr_err;
    logic [W-1:0] data_out;
    logic         data_vld, frm_err, ovr_err;

    bit           tx[$];
    logic [W-1:0] rx[$], exp_q[$];
    int           frm_cnt, exp_frm;
    int           checks = 0, failures = 0;

    dff_stream_deser #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .bit_vld(bit_vld),
        .data_out(data_out), .data_vld(data_vld), .data_rdy(data_rdy),
        .frm_err(frm_err), .ovr_err(ovr_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Inputs only change just after rising edges, so the falling edge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_vld && data_rdy) rx.push_back(data_out);
            if (frm_err) frm_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input int gap);
        ser_in = b;
        bit_vld = 1'b1;
        tx.push_back(b);
        step();
        bit_vld = 1'b0;
        ser_in = 1'($urandom_range(0, 1));
        repeat (gap) step();
        ser_in = 1'b1;
    endtask

    task automatic send_data(input logic [W-1:0] v, input int gap);
        for (int k = 0; k < W; k++) send_bit(v[k], gap);
    endtask

    task automatic send_frame(input logic [W-1:0] v, input bit stop, input int gap);
        send_bit(1'b0, gap);
        send_data(v, gap);
        send_bit(stop, gap);
    endtask

    task automatic drain(input int n);
        bit_vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_logs();
        tx.delete();
        rx.delete();
        frm_cnt = 0;
    endtask

    // Scan the transmitted bit list: a 0 opens a frame, W data bits follow LSB first,
    // then a stop bit; a bad stop counts an error and skips until the line is high.
    task automatic model_parse();
        int i = 0;
        bit stop;
        logic [W-1:0] w;
        exp_q.delete();
        exp_frm = 0;
        while (i < tx.size()) begin
            if (tx[i]) i++;
            else if (i + W + 1 >= tx.size()) i = tx.size();
            else begin
                for (int k = 0; k < W; k++) w[k] = tx[i + 1 + k];
                stop = tx[i + W + 1];
                i += W + 2;
                if (stop) exp_q.push_back(w);
                else begin
                    exp_frm++;
                    while (i < tx.size() && !tx[i]) i++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bit_vld = 1'b0; ser_in = 1'b1; data_rdy = 1'b0; clr_err = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        checks++; if (data_vld !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b expected 0", data_vld); end
        checks++; if (data_out !== '0) begin failures++; $display("FAIL rst_data: got %h expected 00", data_out); end
        checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL rst_frm: got %b expected 0", frm_err); end
        checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL rst_ovr: got %b expected 0", ovr_err); end
        send_frame(8'h5A, 1'b1, 0);
        checks++; if (data_vld !== 1'b1 || data_out !== 8'h5A) begin failures++; $display("FAIL pre_reset_word: got vld=%b data=%h expected vld=1 data=5a", data_vld, data_out); end
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (data_vld !== 1'b0 || data_out !== '0) begin failures++; $display("FAIL async_reset: got vld=%b data=%h expected vld=0 data=00", data_vld, data_out); end
        step();
        rst_n = 1'b1;
        data_rdy = 1'b1;
        clear_logs();
        send_bit(1'b0, 0);
        send_data(8'hA5, 0);
        checks++; if (data_vld !== 1'b0) begin failures++; $display("FAIL vld_before_stop: got %b expected 0", data_vld); end
        send_bit(1'b1, 0);
        checks++; if (data_vld !== 1'b1 || data_out !== 8'hA5) begin failures++; $display("FAIL vld_after_stop: got vld=%b data=%h expected vld=1 data=a5", data_vld, data_out); end
        drain(3);
        checks++; if (rx.size() !== 1) begin failures++; $display("FAIL reset_word_count: got %0d expected 1", rx.size()); end
        else begin checks++; if (rx[0] !== 8'hA5) begin failures++; $display("FAIL reset_word: got %h expected a5", rx[0]); end end
        checks++; if (frm_cnt !== 0) begin failures++; $display("FAIL reset_frm: got %0d expected 0", frm_cnt); end
    endtask

    task automatic test_stall();
        clear_logs();
        data_rdy = 1'b1;
        send_bit(1'b0, 2);
        send_data(8'h3C, 2);
        checks++; if (data_vld !== 1'b0) begin failures++; $display("FAIL stall_early_vld: got %b expected 0", data_vld); end
        send_bit(1'b1, 0);
        checks++; if (data_vld !== 1'b1 || data_out !== 8'h3C) begin failures++; $display("FAIL stall_word: got vld=%b data=%h expected vld=1 data=3c", data_vld, data_out); end
        drain(3);
        model_parse();
        checks++; if (rx.size() !== exp_q.size()) begin failures++; $display("FAIL stall_count: got %0d expected %0d", rx.size(), exp_q.size()); end
        for (int k = 0; k < rx.size() && k < exp_q.size(); k++) begin
            checks++; if (rx[k] !== exp_q[k]) begin failures++; $display("FAIL stall_data[%0d]: got %h expected %h", k, rx[k], exp_q[k]); end
        end
    endtask

    task automatic test_frame_err();
        clear_logs();
        data_rdy = 1'b1;
        send_frame(8'h81, 1'b0, 0);
        checks++; if (frm_err !== 1'b1) begin failures++; $display("FAIL frm_pulse: got %b expected 1", frm_err); end
        send_bit(1'b0, 0);
        checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL frm_one_cycle: got %b expected 0", frm_err); end
        repeat (4) send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_frame(8'h7E, 1'b1, 0);
        drain(3);
        model_parse();
        checks++; if (frm_cnt !== exp_frm) begin failures++; $display("FAIL frm_count: got %0d expected %0d", frm_cnt, exp_frm); end
        checks++; if (rx.size() !== exp_q.size()) begin failures++; $display("FAIL frm_words: got %0d expected %0d", rx.size(), exp_q.size()); end
        for (int k = 0; k < rx.size() && k < exp_q.size(); k++) begin
            checks++; if (rx[k] !== exp_q[k]) begin failures++; $display("FAIL frm_data[%0d]: got %h expected %h", k, rx[k], exp_q[k]); end
        end
    endtask

    task automatic test_overrun();
        clear_logs();
        data_rdy = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 1);
        checks++; if (data_vld !== 1'b1 || data_out !== 8'h11) begin failures++; $display("FAIL ovr_hold: got vld=%b data=%h expected vld=1 data=11", data_vld, data_out); end
        checks++; if (ovr_err !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", ovr_err); end
        send_bit(1'b0, 0);
        send_data(8'h33, 0);
        clr_err = 1'b1;
        send_bit(1'b1, 0);
        clr_err = 1'b0;
        checks++; if (ovr_err !== 1'b1 || data_out !== 8'h11) begin failures++; $display("FAIL ovr_set_wins: got ovr=%b data=%h expected ovr=1 data=11", ovr_err, data_out); end
        clr_err = 1'b1;
        data_rdy = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (ovr_err !== 1'b0 || data_vld !== 1'b0) begin failures++; $display("FAIL ovr_clear: got ovr=%b vld=%b expected ovr=0 vld=0", ovr_err, data_vld); end
        drain(2);
        checks++; if (rx.size() !== 1) begin failures++; $display("FAIL ovr_word_count: got %0d expected 1", rx.size()); end
        else begin checks++; if (rx[0] !== 8'h11) begin failures++; $display("FAIL ovr_word: got %h expected 11", rx[0]); end end
    endtask

    task automatic test_same_edge();
        clear_logs();
        data_rdy = 1'b0;
        send_frame(8'h55, 1'b1, 0);
        send_bit(1'b0, 0);
        send_data(8'hAA, 0);
        data_rdy = 1'b1;
        send_bit(1'b1, 0);
        checks++; if (data_vld !== 1'b1 || data_out !== 8'hAA || ovr_err !== 1'b0) begin failures++; $display("FAIL same_edge: got vld=%b data=%h ovr=%b expected vld=1 data=aa ovr=0", data_vld, data_out, ovr_err); end
        drain(3);
        model_parse();
        checks++; if (rx.size() !== exp_q.size()) begin failures++; $display("FAIL same_edge_count: got %0d expected %0d", rx.size(), exp_q.size()); end
        for (int k = 0; k < rx.size() && k < exp_q.size(); k++) begin
            checks++; if (rx[k] !== exp_q[k]) begin failures++; $display("FAIL same_edge_data[%0d]: got %h expected %h", k, rx[k], exp_q[k]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        data_rdy = 1'b1;
        for (int n = 0; n < 20; n++) send_frame(W'($urandom), 1'b1, 0);
        drain(3);
        model_parse();
        checks++; if (rx.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", rx.size(), exp_q.size()); end
        for (int k = 0; k < rx.size() && k < exp_q.size(); k++) begin
            checks++; if (rx[k] !== exp_q[k]) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, rx[k], exp_q[k]); end
        end
        checks++; if (frm_cnt !== 0 || ovr_err !== 1'b0) begin failures++; $display("FAIL b2b_errors: got frm=%0d ovr=%b expected frm=0 ovr=0", frm_cnt, ovr_err); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_frame_err();
        test_overrun();
        test_same_edge();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dff_stream_deser.md
# dff_stream_deser

- Serial-to-parallel receive stage, directly downstream of the single-bit D flip-flop stage; its `ser_in` connects to the flop's `q`.
- Frames the bit stream as: start bit 0, `DATA_W` data bits LSB-first, stop bit 1.
- Presents each received word on a valid/ready output port.
- Reports framing errors (pulse) and overruns (sticky flag).

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 2..16.

Ports:
- `clk`, input, 1: single clock; all logic samples on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `ser_in`, input, 1: serial bit from the upstream flop's `q`.
- `bit_vld`, input, 1: `ser_in` holds a valid bit this cycle; when low, the block ignores `ser_in` and FSM, counter and shift register hold.
- `data_out`, output, `DATA_W`: received word.
- `data_vld`, output, 1: `data_out` is valid.
- `data_rdy`, input, 1: consumer accepts the word.
- `frm_err`, output, 1: one-cycle pulse on a bad stop bit.
- `ovr_err`, output, 1: sticky overrun flag.
- `clr_err`, input, 1: synchronous clear of `ovr_err`.

## Operation
- States:
  - IDLE: wait for a start bit.
  - DATA: shift in data bits.
  - STOP: check the stop bit.
  - RESYNC: wait for line high after an error.
- All transitions occur only on cycles with `bit_vld`=1.
- IDLE: `ser_in`=0 moves to DATA and clears bit counter `cnt` to 0; `ser_in`=1 stays in IDLE.
- DATA: `ser_in` goes into shift register bit `cnt` (LSB first), then `cnt` increments. When `cnt`==`DATA_W`-1, move to STOP. `cnt` is `$clog2(DATA_W)` bits wide and never wraps.
- STOP, `ser_in`=1: word is complete; return to IDLE.
  - If the output register is empty, or is being emptied this same cycle (`data_vld`&`data_rdy`), load `data_out` and set `data_vld`.
  - Otherwise drop the word, set `ovr_err`, and leave `data_out` unchanged.
- STOP, `ser_in`=0: pulse `frm_err`, drop the word, move to RESYNC.
- RESYNC: `ser_in`=1 moves to IDLE; `ser_in`=0 stays in RESYNC. A held-low line therefore yields exactly one `frm_err`.
- Output handshake:
  - Transfer occurs when `data_vld`&`data_rdy` at a clock edge.
  - `data_vld` stays high and `data_out` stays stable until the transfer.
  - `data_rdy` may be high while `data_vld` is low; this has no effect.
- Simultaneous transfer and new-word load on the same edge: new word loads, `data_vld` stays 1, no overrun.
- `ovr_err` clear/set priority: `clr_err` clears it unless an overrun occurs in the same cycle; in that case set wins.
- Output register is one word deep; there is no further buffering.

## Timing
- Reset values (async, immediate on `rst_n` low): state IDLE, `cnt` 0, shift register 0, `data_out` 0, `data_vld` 0, `frm_err` 0, `ovr_err` 0.
- Reset asserted mid-frame aborts the frame; no partial word is ever presented.
- Latency: the stop bit is sampled at edge N; `data_vld`=1 and `data_out` are visible after edge N (cycle N+1).
- `frm_err` is high for exactly the cycle after the bad stop-bit edge.
- Minimum frame is `DATA_W`+2 `bit_vld` cycles. Gaps with `bit_vld`=0 of any length are allowed anywhere within a frame.
- Back-to-back frames: a start bit may immediately follow a stop bit on the next `bit_vld` cycle.
- Outputs are registered; there is no combinational path from `ser_in` or `data_rdy` to any output.

## Test plan
- Reset check: `rst_n` low mid-DATA, release, send frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1) with `data_rdy`=1 → exactly one word 0xA5, `data_vld` one cycle after the stop edge, no error.
- Stalled bits: frame 0x3C with `bit_vld` toggling 1,0,0,1,… → `data_out`=0x3C; `cnt` and state hold while `bit_vld`=0.
- Framing error: frame 0x81 with stop bit 0, then line held 0 for 5 bits, then 1, then frame 0x7E → one `frm_err` pulse, 0x81 never presented, 0x7E received.
- Overrun: `data_rdy`=0, frames 0x11 then 0x22 → `data_out` stays 0x11, `ovr_err`=1. Then `clr_err`=1, `data_rdy`=1 → `ovr_err`=0, 0x11 accepted.
- Same-edge accept and load: `data_rdy` rises on the stop-bit edge of a back-to-back second frame (0x55 then 0xAA) → both words transferred, no overrun.
- Back-to-back stream: 20 random frames with `data_rdy`=1 → every word received in order, no errors.
